// File: rtl/niosii_esercitazione_pio_in.sv
// Avalon-MM input PIO: synchronizes external inputs, latches selected edges
// into sticky capture bits and raises a masked level interrupt.
// Per-bit state lives in niosii_esercitazione_pio_in_bit, one instance per input.

module niosii_esercitazione_pio_in_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic mask_we,
  input  logic mask_wd,
  input  logic cap_clr,
  output logic sync,
  output logic mask,
  output logic cap
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   edge_det;

  assign sync = chain[SYNC_STAGES-1];

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= sync;
    end
  end

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_det = sync & ~prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_det = ~sync & prev;
  end else begin : g_any
    assign edge_det = sync ^ prev;
  end

  // Interrupt enable bit, software-written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     mask <= 1'b0;
    else if (mask_we) mask <= mask_wd;
  end

  // Sticky capture; a detected edge beats a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cap <= 1'b0;
    else if (edge_det) cap <= 1'b1;
    else if (cap_clr)  cap <= 1'b0;
  end
endmodule

module niosii_esercitazione_pio_in #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic             wr;
  logic             mask_we;
  logic             cap_we;
  logic [WIDTH-1:0] sync_vec;
  logic [WIDTH-1:0] mask_vec;
  logic [WIDTH-1:0] cap_vec;

  assign wr      = chipselect & ~write_n;
  assign mask_we = wr & (address == 2'd2);
  assign cap_we  = wr & (address == 2'd3);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    niosii_esercitazione_pio_in_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[gi]),
      .mask_we (mask_we),
      .mask_wd (writedata[gi]),
      .cap_clr (cap_we & writedata[gi]),
      .sync    (sync_vec[gi]),
      .mask    (mask_vec[gi]),
      .cap     (cap_vec[gi])
    );
  end

  // Upper write-data bits have no register behind them.
  if (WIDTH < 32) begin : g_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  // Read mux is decoded from address alone, not gated by chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = sync_vec;
      2'd2:    readdata[WIDTH-1:0] = mask_vec;
      2'd3:    readdata[WIDTH-1:0] = cap_vec;
      default: readdata = '0;
    endcase
  end

  assign irq = |(cap_vec & mask_vec);
endmodule

// File: tb/tb_niosii_esercitazione_pio_in.sv
// Bench for the input PIO: three instances (rising, falling, any edge) share
// one bus and one input vector and are checked against a history-based model.
module tb_niosii_esercitazione_pio_in;
  localparam int W = 10;
  localparam int S = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [W-1:0]      in_port;
  logic [2:0][31:0]  rd;
  logic [2:0]        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  niosii_esercitazione_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq[0]));
  niosii_esercitazione_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq[1]));
  niosii_esercitazione_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq[2]));

  // Model: hist[i] is the input sampled i+1 edges ago (hist[0] = latest).
  logic [W-1:0] hist [0:S];
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [0:2];

  function automatic logic [W-1:0] edges(int t, logic [W-1:0] s, logic [W-1:0] p);
    if (t == 0)      return s & ~p;
    else if (t == 1) return ~s & p;
    else             return s ^ p;
  endfunction

  function automatic logic [31:0] exp_read(int k);
    logic [31:0] r;
    r = '0;
    case (address)
      2'd0: r[W-1:0] = hist[S-1];
      2'd2: r[W-1:0] = m_mask;
      2'd3: r[W-1:0] = m_cap[k];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= S; i++) hist[i] = '0;
    m_mask = '0;
    for (int k = 0; k < 3; k++) m_cap[k] = '0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_rd_et%0d_a%0d", k, address), rd[k], exp_read(k));
      check($sformatf("model_irq_et%0d", k), {31'd0, irq[k]}, {31'd0, |(m_cap[k] & m_mask)});
    end
  endtask

  // One clock edge: predict next state from the pre-edge inputs, then compare.
  task automatic tick();
    logic [W-1:0] nc [0:2];
    logic [W-1:0] nm;
    logic         wr;
    logic         rn;
    wr = chipselect & ~write_n;
    rn = reset_n;
    for (int k = 0; k < 3; k++) begin
      nc[k] = m_cap[k] | edges(k, hist[S-1], hist[S]);
      if (wr && address == 2'd3)
        nc[k] = (m_cap[k] & ~writedata[W-1:0]) | edges(k, hist[S-1], hist[S]);
    end
    nm = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
    @(posedge clk);
    if (rn) begin
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_port;
      m_mask = nm;
      for (int k = 0; k < 3; k++) m_cap[k] = nc[k];
    end else begin
      model_reset();
    end
    #1;
    check_all();
  endtask

  task automatic bus(logic [1:0] a, logic cs, logic wn, logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
  endtask

  typedef struct {
    logic [1:0]   addr;
    logic         cs;
    logic         wr_n;
    logic [31:0]  wd;
    logic [W-1:0] inp;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // Directed vectors for the rising-edge instance; each row is one edge.
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h000, 1'b0};
    vecs[1]  = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h2A5, 1'b0};
    vecs[2]  = '{2'd1, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h000, 1'b0};
    vecs[3]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h2A5, 1'b0};
    vecs[4]  = '{2'd3, 1'b1, 1'b0, 32'h3FF,      10'h2A5, 32'h000, 1'b0};
    vecs[5]  = '{2'd2, 1'b1, 1'b0, 32'h001,      10'h2A4, 32'h001, 1'b0};
    vecs[6]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h000, 1'b0};
    vecs[7]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h000, 1'b0};
    vecs[8]  = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h001, 1'b1};
    vecs[9]  = '{2'd3, 1'b1, 1'b0, 32'h001,      10'h2A5, 32'h000, 1'b0};
    vecs[10] = '{2'd2, 1'b1, 1'b0, 32'h000,      10'h285, 32'h000, 1'b0};
    vecs[11] = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h285, 1'b0};
    vecs[12] = '{2'd0, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h2A5, 1'b0};
    vecs[13] = '{2'd3, 1'b0, 1'b1, 32'h0,        10'h2A5, 32'h020, 1'b0};
    vecs[14] = '{2'd2, 1'b1, 1'b0, 32'h020,      10'h2A5, 32'h020, 1'b1};
    vecs[15] = '{2'd3, 1'b0, 1'b0, 32'h3FF,      10'h2A5, 32'h020, 1'b1};
    vecs[16] = '{2'd0, 1'b1, 1'b0, 32'h3FF,      10'h2A5, 32'h2A5, 1'b1};
    vecs[17] = '{2'd1, 1'b1, 1'b0, 32'h3FF,      10'h2A5, 32'h000, 1'b1};
    vecs[18] = '{2'd3, 1'b1, 1'b0, 32'h01F,      10'h2A5, 32'h020, 1'b1};
    vecs[19] = '{2'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 10'h2A5, 32'h000, 1'b0};

    // Reset state, asserted away from any clock edge.
    reset_n = 1'b0;
    in_port = '0;
    bus(2'd0, 1'b0, 1'b1, 32'h0);
    model_reset();
    #12;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("reset_rd_a%0d", a), rd[0], 32'h0);
      check("reset_irq", {31'd0, irq[0]}, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 20; i++) begin
      bus(vecs[i].addr, vecs[i].cs, vecs[i].wr_n, vecs[i].wd);
      in_port = vecs[i].inp;
      tick();
      check($sformatf("vec%0d_rd", i), rd[0], vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq[0]}, {31'd0, vecs[i].exp_irq});
    end

    // Set beats clear: bit-3 edge lands on the same edge as a full clear.
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port = 10'h000; repeat (3) tick();
    in_port = 10'h0F0; repeat (3) tick();
    in_port = 10'h0F8; repeat (2) tick();
    bus(2'd3, 1'b1, 1'b0, 32'h3FF);
    tick();
    check("set_beats_clear_rise", rd[0], 32'h008);
    check("set_beats_clear_any",  rd[2], 32'h008);

    // Bit-0 pulse across the three edge types.
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port = 10'h000; repeat (3) tick();
    bus(2'd3, 1'b1, 1'b0, 32'hFFFFFFFF); tick();
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port = 10'h001; tick(); tick();
    in_port = 10'h000; tick();
    check("pulse_rise_et0", rd[0], 32'h001);
    check("pulse_rise_et1", rd[1], 32'h000);
    check("pulse_rise_et2", rd[2], 32'h001);
    bus(2'd3, 1'b1, 1'b0, 32'h001); tick();
    check("pulse_clr_et2", rd[2], 32'h000);
    bus(2'd3, 1'b0, 1'b1, 32'h0); tick();
    check("pulse_fall_et0", rd[0], 32'h000);
    check("pulse_fall_et1", rd[1], 32'h001);
    check("pulse_fall_et2", rd[2], 32'h001);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      writedata  = (address == 2'd3) ? ($urandom() & $urandom()) : $urandom();
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom());
      tick();
    end

    // Reset mid-operation: state clears without a clock and stays clear.
    bus(2'd2, 1'b1, 1'b0, 32'h3FF); tick();
    bus(2'd0, 1'b0, 1'b1, 32'h0);
    reset_n = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("midreset_rd_a%0d", a), rd[0], 32'h0);
      check("midreset_irq", {31'd0, irq[0]}, 32'h0);
    end
    address = 2'd3;
    for (int i = 0; i < 3; i++) begin
      in_port = (i % 2 == 0) ? 10'h3FF : 10'h000;
      tick();
    end
    in_port = 10'h3FF;
    reset_n = 1'b1;
    repeat (4) tick();
    check("post_reset_capture_high_input", rd[0], 32'h3FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
